// File: rtl/aes_round_seq.sv
// aes_round_seq: control sequencer for an iterative AES-128/192/256 round datapath.
// Walks RES, ADD, {SUB, SHI, MIX, ADD} rounds and a final FIN hold with an out_valid handshake.
module aes_round_seq #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       res,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] stage,
    output logic [3:0] round,
    output logic       st_we,
    output logic       key_we,
    output logic       load,
    output logic       busy
);
    localparam logic [3:0] LAST = 4'(NR);

    // State codes equal the stage codes; IDLE takes the unused 011 slot.
    typedef enum logic [2:0] {
        S_RES  = 3'b000,
        S_ADD  = 3'b001,
        S_SUB  = 3'b010,
        S_IDLE = 3'b011,
        S_SHI  = 3'b100,
        S_MIX  = 3'b101,
        S_FIN  = 3'b111
    } state_t;

    state_t     state, nxt;
    logic [3:0] nround;
    logic       last;

    assign last     = round == LAST;
    assign in_ready = state == S_IDLE;

    always_comb begin
        nxt    = S_IDLE;
        nround = round;
        case (state)
            S_IDLE: begin
                nxt    = in_valid ? S_RES : S_IDLE;
                nround = in_valid ? 4'd0 : round;
            end
            S_RES: begin
                nxt    = S_ADD;
                nround = 4'd0;
            end
            S_ADD: begin
                nxt    = last ? S_FIN : S_SUB;
                nround = last ? round : round + 4'd1;
            end
            S_SUB:   nxt = S_SHI;
            S_SHI:   nxt = last ? S_ADD : S_MIX;
            S_MIX:   nxt = S_ADD;
            S_FIN:   nxt = out_ready ? S_IDLE : S_FIN;
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!res) begin
            state     <= S_IDLE;
            round     <= 4'd0;
            stage     <= 3'b000;
            st_we     <= 1'b0;
            key_we    <= 1'b0;
            load      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            round     <= nround;
            stage     <= nxt == S_IDLE ? 3'b000 : nxt;
            st_we     <= nxt inside {S_RES, S_ADD, S_SUB, S_SHI, S_MIX};
            key_we    <= nxt == S_RES || nxt == S_SHI;
            load      <= nxt == S_RES;
            out_valid <= nxt == S_FIN;
            busy      <= nxt != S_IDLE;
        end
    end
endmodule
